axis_multichannel_integrator: RTL and testbench

//  Per-channel integrator for channel-interleaved AXI-Stream frames (ch 0..CHANNELS-1, tlast on last).
//  - Sums each channel over cfg_frames consecutive frames in on-chip RAM.
//  - Emits one integrated frame on m_axis, then restarts; sits after FFT/power stages in spectrometer chains.

---
 rtl/axis_mcacc_pkg.sv | 38 +++
 rtl/axis_mcacc_ram.sv | 30 +++
 rtl/axis_multichannel_integrator.sv | 186 ++++++++++++++++++
 tb/tb_axis_multichannel_integrator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mcacc_pkg.sv
// Shared types and arithmetic for the multichannel AXI-Stream integrator.
// AXIS_MCACC_SATURATE_EN selects clamping adds; otherwise adds wrap.
package axis_mcacc_pkg;

    typedef enum logic [1:0] {
        PH_FIRST,
        PH_ACCUM,
        PH_LAST
    } phase_t;

    localparam int unsigned DEF_CHANNELS  = 1024;
    localparam int unsigned SUM_MAX_WIDTH = 64;

    typedef logic [SUM_MAX_WIDTH-1:0] wide_t;

    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands are zero-extended to SUM_MAX_WIDTH; width is the accumulator width.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned width);
        wide_t max_val;
`ifdef AXIS_MCACC_SATURATE_EN
        logic [SUM_MAX_WIDTH:0] sum;
        max_val = (wide_t'(1) << width) - wide_t'(1);
        sum     = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            sat_add = max_val;
        end else begin
            sat_add = sum[SUM_MAX_WIDTH-1:0];
        end
`else
        max_val = (wide_t'(1) << width) - wide_t'(1);
        sat_add = (a + b) & max_val;
`endif
    endfunction

endpackage

// File: rtl/axis_mcacc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port with enable.
module axis_mcacc_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_multichannel_integrator.sv
// Per-channel frame integrator for channel-interleaved AXI-Stream data.
// Define AXIS_MCACC_SATURATE_EN for clamping accumulation instead of wrap-around.
module axis_multichannel_integrator
    import axis_mcacc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned FRAME_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [ACC_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    input  logic [FRAME_WIDTH-1:0] cfg_frames,
    output logic                   frame_error
);

    localparam int unsigned CHAN_WIDTH = chan_width(CHANNELS);
    localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(CHANNELS - 1);

    typedef logic [ACC_WIDTH-1:0]   acc_t;
    typedef logic [FRAME_WIDTH-1:0] frame_t;

    logic                  adv;
    logic                  accept;
    logic                  start;
    logic                  at_last_chan;
    logic                  mismatch;
    logic                  first;
    phase_t                phase;
    frame_t                cfg_n;
    frame_t                n_eff;

    logic [CHAN_WIDTH-1:0] chan_q, chan_d;
    frame_t                frame_q, frame_d;
    frame_t                n_q, n_d;

    logic                  s1_valid_q;
    logic                  s1_first_q;
    phase_t                s1_phase_q;
    logic                  s1_tlast_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [CHAN_WIDTH-1:0] s1_chan_q;

    acc_t                  ram_rdata;
    acc_t                  sum;
    logic                  ram_wr_en;
    logic                  out_load;

    logic                  m_valid_q;
    logic                  m_last_q;
    acc_t                  m_data_q;
    logic                  frame_error_q;

    assign adv           = !m_valid_q || m_axis_tready;
    assign s_axis_tready = aresetn && adv;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign cfg_n        = (cfg_frames == '0) ? FRAME_WIDTH'(1) : cfg_frames;
    assign start        = (chan_q == '0) && (frame_q == '0);
    assign n_eff        = start ? cfg_n : n_q;
    assign at_last_chan = (chan_q == LAST_CHAN);
    assign mismatch     = s_axis_tlast != at_last_chan;
    assign first        = (frame_q == '0);

    // With N=1 frame 0 is both first and last; "first" is carried separately.
    always_comb begin
        if (frame_q == n_eff - FRAME_WIDTH'(1)) begin
            phase = PH_LAST;
        end else if (first) begin
            phase = PH_FIRST;
        end else begin
            phase = PH_ACCUM;
        end
    end

    always_comb begin
        chan_d  = chan_q;
        frame_d = frame_q;
        n_d     = n_q;
        if (accept) begin
            if (start) begin
                n_d = cfg_n;
            end
            if (mismatch) begin
                chan_d  = '0;
                frame_d = '0;
            end else if (at_last_chan) begin
                chan_d  = '0;
                frame_d = (phase == PH_LAST) ? '0 : frame_q + FRAME_WIDTH'(1);
            end else begin
                chan_d = chan_q + CHAN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            chan_q  <= '0;
            frame_q <= '0;
            n_q     <= FRAME_WIDTH'(1);
        end else begin
            chan_q  <= chan_d;
            frame_q <= frame_d;
            n_q     <= n_d;
        end
    end

    axis_mcacc_ram #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (CHANNELS),
        .AW    (CHAN_WIDTH)
    ) u_ram (
        .clk_i     (aclk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (s1_chan_q),
        .wr_data_i (sum),
        .rd_en_i   (adv),
        .rd_addr_i (chan_q),
        .rd_data_o (ram_rdata)
    );

    always_comb begin
        sum = '0;
        if (s1_first_q) begin
            sum = acc_t'(s1_data_q);
        end else begin
            sum = ACC_WIDTH'(sat_add(wide_t'(ram_rdata), wide_t'(s1_data_q), ACC_WIDTH));
        end
    end

    assign ram_wr_en = adv && s1_valid_q && (s1_phase_q != PH_LAST);
    assign out_load  = s1_valid_q && (s1_phase_q == PH_LAST);

    // An erroneous beat in the last frame closes the output frame so it still ends with tlast.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_phase_q <= PH_FIRST;
            s1_tlast_q <= 1'b0;
            s1_data_q  <= '0;
            s1_chan_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_first_q <= first;
                s1_phase_q <= phase;
                s1_tlast_q <= at_last_chan || s_axis_tlast;
                s1_data_q  <= s_axis_tdata;
                s1_chan_q  <= chan_q;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            m_data_q      <= '0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= accept && mismatch;
            if (adv) begin
                m_valid_q <= out_load;
                m_last_q  <= out_load && s1_tlast_q;
                if (out_load) begin
                    m_data_q <= sum;
                end
            end
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_data_q;
    assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_axis_multichannel_integrator.sv
// Scoreboard bench for axis_multichannel_integrator (CHANNELS=4, 8-bit in, 9-bit acc).
module tb_axis_multichannel_integrator;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 9;
    localparam int unsigned CH = 4;
    localparam int unsigned FW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [FW-1:0] cfg_frames = 16'd1;
    logic          frame_error;

    axis_multichannel_integrator #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .CHANNELS    (CH),
        .FRAME_WIDTH (FW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .cfg_frames    (cfg_frames),
        .frame_error   (frame_error)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [AW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    fe_count = 0;
    int    first_out_cyc = -1;
    int    acc_cyc = -1;

    always @(posedge aclk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge aclk) begin
        if (m_axis_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
        if (frame_error) fe_count++;
        if (aresetn) begin
            checks++;
            if (s_axis_tready !== (!m_axis_tvalid || m_axis_tready)) begin
                errors++;
                $display("FAIL s_tready_adv got %b exp %b", s_axis_tready,
                         !m_axis_tvalid || m_axis_tready);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got data=%0d last=%b exp none",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last) begin
                        errors++;
                        $display("FAIL out_beat got data=%0d last=%b exp data=%0d last=%b",
                                 m_axis_tdata, m_axis_tlast, mon_e.data, mon_e.last);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            ok = s_axis_tready;
            if (ok && acc_cyc < 0) acc_cyc = cyc;
            @(posedge aclk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout got no_accept exp accept data=%0d", d);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] v0, v1, v2, v3);
        send_beat(v0, 1'b0);
        send_beat(v1, 1'b0);
        send_beat(v2, 1'b0);
        send_beat(v3, 1'b1);
    endtask

    task automatic push_exp(input logic [AW-1:0] e0, e1, e2, e3);
        exp_q.push_back('{data: e0, last: 1'b0});
        exp_q.push_back('{data: e1, last: 1'b0});
        exp_q.push_back('{data: e2, last: 1'b0});
        exp_q.push_back('{data: e3, last: 1'b1});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge aclk);
        repeat (4) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks += 5;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", m_axis_tlast); end
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %0d exp 0", m_axis_tdata); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b exp 0", frame_error); end
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_axis_tready); end
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_passthrough();
        cfg_frames    = 16'd1;
        first_out_cyc = -1;
        acc_cyc       = -1;
        push_exp(9'd1, 9'd2, 9'd3, 9'd4);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain();
        checks += 2;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL pass_drain got %0d left exp 0", exp_q.size()); end
        if (first_out_cyc - acc_cyc !== 2) begin
            errors++;
            $display("FAIL pass_latency got %0d exp 2", first_out_cyc - acc_cyc);
        end
    endtask

    task automatic test_integrate();
        cfg_frames = 16'd3;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'd1, 8'd2, 8'd3, 8'd4);
            send_frame(8'd1, 8'd2, 8'd3, 8'd4);
            push_exp(9'd3, 9'd6, 9'd9, 9'd12);
            send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        end
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL integ_drain got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit done;
        done = 1'b0;
        cfg_frames = 16'd3;
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
                    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
                    push_exp(9'd3, 9'd6, 9'd9, 9'd12);
                    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
                end
                for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge aclk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1;
                    m_axis_tready = !m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_drain got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        logic [AW-1:0] e;
`ifdef AXIS_MCACC_SATURATE_EN
        e = 9'h1FF;
`else
        e = 9'h0FD;
`endif
        cfg_frames = 16'd3;
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_exp(e, e, e, e);
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_drain();
        checks += 2;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL sat_drain got %0d left exp 0", exp_q.size()); end
        if (fe_count !== 0) begin errors++; $display("FAIL clean_ferr got %0d exp 0", fe_count); end
    endtask

    task automatic test_frame_error();
        int fe0;
        fe0 = fe_count;
        cfg_frames = 16'd3;
        send_frame(8'd1, 8'd1, 8'd1, 8'd1);
        send_beat(8'd90, 1'b0);
        send_beat(8'd90, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (fe_count !== fe0 + 1) begin errors++; $display("FAIL ferr_early_tlast got %0d exp %0d", fe_count, fe0 + 1); end
        send_frame(8'd10, 8'd20, 8'd30, 8'd40);
        send_frame(8'd10, 8'd20, 8'd30, 8'd40);
        push_exp(9'd30, 9'd60, 9'd90, 9'd120);
        send_frame(8'd10, 8'd20, 8'd30, 8'd40);
        wait_drain();
        // Missing tlast on the final channel.
        send_frame(8'd5, 8'd5, 8'd5, 8'd5);
        for (int i = 0; i < 4; i++) send_beat(8'd70, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (fe_count !== fe0 + 2) begin errors++; $display("FAIL ferr_no_tlast got %0d exp %0d", fe_count, fe0 + 2); end
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        push_exp(9'd3, 9'd6, 9'd9, 9'd12);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL ferr_drain got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        cfg_frames = 16'd3;
        send_frame(8'd50, 8'd50, 8'd50, 8'd50);
        send_frame(8'd50, 8'd50, 8'd50, 8'd50);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        checks += 3;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b exp 0", m_axis_tvalid); end
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got %b exp 0", s_axis_tready); end
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL midrst_tdata got %0d exp 0", m_axis_tdata); end
        aresetn = 1'b1;
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        push_exp(9'd3, 9'd6, 9'd9, 9'd12);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_drain got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_cfg_latch();
        cfg_frames = 16'd2;
        send_beat(8'd1, 1'b0);
        cfg_frames = 16'd5;
        send_beat(8'd2, 1'b0);
        send_beat(8'd3, 1'b0);
        send_beat(8'd4, 1'b1);
        push_exp(9'd2, 9'd4, 9'd6, 9'd8);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain();
        cfg_frames = 16'd0;
        push_exp(9'd7, 9'd8, 9'd9, 9'd10);
        send_frame(8'd7, 8'd8, 8'd9, 8'd10);
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL cfg_drain got %0d left exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_integrate();
        test_backpressure();
        test_saturate();
        test_frame_error();
        test_mid_reset();
        test_cfg_latch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
